// File: rtl/systolic_array_controller_if.sv
// rtl/systolic_array_controller_if.sv - host/DMA and PE-grid signals of the systolic array controller
`timescale 1ns/1ps
interface systolic_array_controller_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
);
  logic            start;
  logic            cfg_reload_w;
  logic            busy;
  logic            done;
  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            x_valid;
  logic            x_ready;
  logic [N*DW-1:0] x_data;
  logic            x_last;
  logic            y_valid;
  logic [N*AW-1:0] y_data;
  logic [N*DW-1:0] pe_weight;
  logic [N-1:0]    pe_load_row;
  logic [N*DW-1:0] pe_data_west;
  logic [N*AW-1:0] pe_psum_north;
  logic [N*AW-1:0] pe_psum_south;

  modport master (
    output start, cfg_reload_w, w_valid, w_data, x_valid, x_data, x_last, pe_psum_south,
    input  busy, done, w_ready, x_ready, y_valid, y_data,
    input  pe_weight, pe_load_row, pe_data_west, pe_psum_north
  );

  modport slave (
    input  start, cfg_reload_w, w_valid, w_data, x_valid, x_data, x_last, pe_psum_south,
    output busy, done, w_ready, x_ready, y_valid, y_data,
    output pe_weight, pe_load_row, pe_data_west, pe_psum_north
  );
endinterface

// File: rtl/systolic_array_controller.sv
// rtl/systolic_array_controller.sv - weight-stationary NxN systolic array sequencer
`timescale 1ns/1ps
module systolic_array_controller #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input logic                     clk,
  input logic                     rst,
  systolic_array_controller_if.slave bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic            wl_q, wl_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    load_row_q, load_row_d;
  logic [N*DW-1:0] weight_q, weight_d;
  logic [2*N-1:0]  tag_q, tag_d;
  logic [N*AW-1:0] y_raw;

  logic w_acc, x_acc, y_valid;
  assign w_acc = (state_q == LOAD_W) && bus.w_valid;
  assign x_acc = (state_q == STREAM) && bus.x_valid;

  always_comb begin
    state_d    = state_q;
    wl_d       = wl_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    load_row_d = '0;
    weight_d   = weight_q;
    tag_d      = {tag_q[2*N-2:0], x_acc};
    case (state_q)
      IDLE: if (bus.start) begin
        row_d   = '0;
        cnt_d   = '0;
        state_d = (bus.cfg_reload_w || !wl_q) ? LOAD_W : STREAM;
      end
      LOAD_W: if (w_acc) begin
        load_row_d = N'(1) << row_q;
        weight_d   = bus.w_data;
        row_d      = row_q + RW'(1);
        if (row_q == RW'(N - 1)) begin
          state_d = STREAM;
          wl_d    = 1'b1;
        end
      end
      STREAM: if (x_acc && bus.x_last) begin
        cnt_d   = '0;
        state_d = DRAIN;
      end
      // The last accepted vector surfaces on y_valid in the final drain cycle.
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * N - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wl_q       <= 1'b0;
      row_q      <= '0;
      cnt_q      <= '0;
      load_row_q <= '0;
      weight_q   <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      wl_q       <= wl_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      load_row_q <= load_row_d;
      weight_q   <= weight_d;
      tag_q      <= tag_d;
    end
  end

  // Row r enters the array r cycles late so that row r meets the psum wavefront.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [DW-1:0] sk_q [r+1];
    logic [DW-1:0] sk_d [r+1];
    always_comb begin
      sk_d[0] = x_acc ? bus.x_data[r*DW +: DW] : '0;
      for (int k = 1; k <= r; k++) sk_d[k] = sk_q[k-1];
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sk_q[k] <= '0;
      end else begin
        sk_q <= sk_d;
      end
    end
    assign bus.pe_data_west[r*DW +: DW] = sk_q[r];
  end

  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_pass
      assign y_raw[c*AW +: AW] = bus.pe_psum_south[c*AW +: AW];
    end else begin : g_dly
      logic [AW-1:0] dk_q [D];
      logic [AW-1:0] dk_d [D];
      always_comb begin
        dk_d[0] = bus.pe_psum_south[c*AW +: AW];
        for (int k = 1; k < D; k++) dk_d[k] = dk_q[k-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dk_q[k] <= '0;
        end else begin
          dk_q <= dk_d;
        end
      end
      assign y_raw[c*AW +: AW] = dk_q[D-1];
    end
  end

  assign y_valid           = tag_q[2*N-1];
  assign bus.y_valid       = y_valid;
  assign bus.y_data        = y_valid ? y_raw : '0;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.w_ready       = (state_q == LOAD_W);
  assign bus.x_ready       = (state_q == STREAM);
  assign bus.pe_load_row   = load_row_q;
  assign bus.pe_weight     = weight_q;
  assign bus.pe_psum_north = '0;
endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
Sequencer for an N×N weight-stationary systolic array of processing elements, with data flowing west→east and partial sums north→south. It runs one job per `start`:
- loads N weight rows through a valid/ready stream, pulsing per-row load enables;
- streams activation vectors into the array's west edge with per-row skew, and drives zero partial sums into the north edge;
- deskews the south-edge partial sums into aligned result vectors.

It sits between the host/DMA streams and the PE grid.

Parameters:
N, 4, array dimension (rows = columns = N), N ≥ 2
DW, 8, signed weight/activation width
AW, 32, signed partial-sum width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
cfg_reload_w  in  1  1 = load new weights for this job; 0 = reuse held weights
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse at job end
w_valid  in  1  weight row valid
w_ready  out  1  weight row accepted when w_valid && w_ready
w_data  in  N*DW  one weight row; column c at [c*DW +: DW]
x_valid  in  1  activation vector valid
x_ready  out  1  activation handshake
x_data  in  N*DW  activation vector; row r at [r*DW +: DW]
x_last  in  1  marks final vector of the job
y_valid  out  1  result vector valid; no backpressure
y_data  out  N*AW  result; column c at [c*AW +: AW]
pe_weight  out  N*DW  weight broadcast to all rows; column c slice to PE(r,c)
pe_load_row  out  N  one-hot row load enable (drives load_weight of row r)
pe_data_west  out  N*DW  west-edge data, row r
pe_psum_north  out  N*AW  north-edge partial sums; constant 0
pe_psum_south  in  N*AW  south-edge partial-sum outputs, column c

Behaviour:
- PE model assumed by timing: data and partial-sum paths are each 1 register per PE; a weight is captured on the edge where load_weight is high; PEs share rst.
- Reset values:
  - FSM = IDLE; `weights_loaded` = 0.
  - All skew/deskew/tag registers = 0.
  - Outputs busy, done, w_ready, x_ready, y_valid, pe_load_row = 0; pe_weight, pe_data_west, y_data = 0.
  - Reset mid-job aborts immediately: no done, no y_valid.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
  - IDLE: `start` → LOAD_W if `cfg_reload_w` or !`weights_loaded`, else → STREAM. `start` outside IDLE is ignored.
  - LOAD_W:
    - w_ready = 1; a 0..N-1 row counter selects the target row.
    - Accept row r at edge E → in the following cycle, pe_load_row = (1<<r) and pe_weight = w_data captured at E.
    - After row N-1 is accepted → STREAM and `weights_loaded` ← 1.
  - STREAM:
    - x_ready = 1.
    - Accepted vector: element r is presented on pe_data_west row r in cycle T+1+r, where T is the accept cycle. Row r has r+1 skew registers.
    - Non-accept cycle: zeros are injected with tag 0 (a bubble).
    - Accept with x_last → DRAIN.
  - DRAIN:
    - x_ready = 0; zeros are injected.
    - The counter runs 2N cycles, until the last vector's y_valid has been issued → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- Latency:
  - South column c is valid in cycle T+N+1+c.
  - Column c is delayed N-1-c further, so all columns align.
  - y_valid = 1 and y_data are presented in cycle T+2N.
- Validity tracking: a 2N-deep valid-tag shift register follows each accept. Bubble spacing on the input is preserved exactly on y_valid. Back-to-back accepts give back-to-back y_valid.
- Arithmetic: y_data column c = Σ_r W[r][c]·x[r]. The result is signed and wraps at AW bits; the controller itself performs no arithmetic.
- The controller never stalls the array. Output has no ready signal, so the consumer must accept every y_valid.

Test Plan:
1. Reset: hold rst 3 cycles mid-STREAM, release → busy=0, y_valid=0, pe_load_row=0, pe_data_west=0; no done and no y_valid afterwards.
2. Identity load: N=4, W=I, cfg_reload_w=1, one vector x=[1,2,3,4] with x_last accepted at T.
   - pe_load_row goes 0001,0010,0100,1000 on successive cycles.
   - y_valid at T+8 with y=[1,2,3,4].
   - done one cycle after the drain ends.
3. Signed streaming: W[r][c]=r+1; three back-to-back vectors [1,-1,2,-2], [1,1,1,1], [-128,0,0,0].
   - y_valid for 3 consecutive cycles.
   - All columns read -3, then 10, then -128.
4. Bubbles: accepts at T, T+2, T+5 → y_valid exactly at T+8, T+10, T+13; no other y_valid.
5. Weight reuse/forcing:
   - After reset, start with cfg_reload_w=0 → w_ready=1 (load forced).
   - A second job with cfg_reload_w=0 → w_ready stays 0 and x_ready is asserted the cycle after start.
6. Extremes: W all -128, x all -128, N=4 → every column = 65536; start pulsed during busy is ignored.
